neuron_controller: RTL and testbench
====================================

# neuron_controller

Sequencer that sits directly upstream of the neuron datapath and drives one layer evaluation end to end. On a `start` pulse it:
- clears the MAC accumulators and neuron output registers;
- walks the shared input/weight memory address across `NUM_INPUTS` elements;
- asserts `enMac` aligned with the one-cycle memory read latency;
- fires a single `enReLU` capture, then pulses `done`.

One controller drives any number of neurons in parallel, because all neurons share `init`, `enMac`, `enReLU` and the read address.

## Interface
Parameters:
- `NUM_INPUTS`, default 62: number of data/weight pairs accumulated per evaluation. Legal range is ≥1.
- `ADDR_WIDTH`, default 6: width of `inAddr`. Must satisfy 2^ADDR_WIDTH ≥ NUM_INPUTS.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request an evaluation; sampled only in IDLE.
- `memRd`  out  1  read strobe to the input and weight memories.
- `inAddr`  out  ADDR_WIDTH  element index, shared by the input and weight memories.
- `init`  out  1  clears the MAC accumulator and neuron result register.
- `enMac`  out  1  accumulate the current data×weight.
- `enReLU`  out  1  capture the saturated activation into the neuron register.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the neuron outputs are valid.

## Operation
- Moore FSM with states IDLE, INIT, READ, DRAIN, RELU, DONE.
- All outputs are registered or decoded from the state register; no combinational path from `start` to any output.
- Reset (`rst`=0, asynchronous):
  - state goes to IDLE and the element counter to 0;
  - every output goes to 0, including `inAddr`=0.
- IDLE:
  - all strobes are 0;
  - `start`=1 moves the FSM to INIT; `start`=0 keeps it in IDLE.
- INIT (1 cycle):
  - `init`=1;
  - counter cleared to 0;
  - next state is READ.
- READ:
  - `memRd`=1 and `inAddr`=counter;
  - counter increments by 1 each cycle;
  - when the counter equals NUM_INPUTS-1, the next state is DRAIN and the counter holds (no wrap, no increment past NUM_INPUTS-1).
- `enMac` is `memRd` delayed by one register stage, because the memories have 1-cycle registered read data. Data for address k is therefore accumulated exactly one cycle after address k is issued.
- DRAIN (1 cycle):
  - `memRd`=0;
  - `enMac`=1 for the final element;
  - next state is RELU.
- RELU (1 cycle):
  - `enReLU`=1; `enMac` is already 0;
  - next state is DONE.
- DONE (1 cycle):
  - `done`=1 and `busy`=1;
  - next state is IDLE.
- Exactly NUM_INPUTS `enMac` cycles occur per evaluation: never more, never fewer.
- `start` asserted while `busy`=1 is ignored and not queued.
- `start` held high continuously yields back-to-back evaluations, with one IDLE cycle between `done` and the next INIT.
- NUM_INPUTS=1: READ lasts one cycle (address 0), then DRAIN.
- Bias is not sequenced here. The top level holds it stable for the whole evaluation.

## Timing
- `start` sampled high at the edge ending cycle 0 gives:
  - INIT in cycle 1;
  - READ in cycles 2 … N+1, with `inAddr`=0 … N-1;
  - `enMac` in cycles 3 … N+2;
  - RELU in cycle N+3;
  - DONE in cycle N+4;
  - IDLE in cycle N+5.
- Latency from the `start` sample to the `done` pulse is N+4 cycles. Minimum start-to-start period under a continuously held `start` is N+5 cycles.
- `init`, `enMac` and `enReLU` are mutually exclusive in every cycle.
- Reset mid-evaluation:
  - outputs clear asynchronously, without waiting for a clock edge;
  - the partial accumulation is abandoned;
  - after release, the controller waits in IDLE for a new `start`;
  - no `done` is produced for the aborted run.

## Test plan
- Reset: N=4, `rst` low → all outputs 0 with no clock edge; after release with `start`=0 for 10 cycles, outputs stay 0 and `busy`=0.
- Nominal N=4, `start` pulse in cycle 0 → checks:
  - `init` in cycle 1;
  - `inAddr` 0,1,2,3 with `memRd` in cycles 2–5;
  - `enMac` in cycles 3–6;
  - `enReLU` in cycle 7 and `done` in cycle 8;
  - `busy` high in cycles 1–8.
- End to end with 4 neurons and memory models, N=62, known data/weights → `enMac` count is 62; captured neuron outputs match the golden model; `done` appears 66 cycles after `start`.
- `start` pulsed in cycles 3 and 5 of a running evaluation → timing identical to the nominal case; no second evaluation begins.
- `start` held high, N=1 → repeating pattern:
  - INIT, READ(addr 0), DRAIN, RELU, DONE, IDLE;
  - period 6 cycles;
  - one `enMac` per period.
- `rst` asserted in cycle 4 of an N=4 run → all outputs 0 immediately; after release, no `done` occurs; a new `start` yields the nominal sequence.

Source files
------------

// File: rtl/neuron_controller.sv
// neuron_controller: sequences one layer evaluation.
// Drives init, memory walk, MAC enable, ReLU capture, done.
module neuron_controller #(
  parameter int NUM_INPUTS = 62,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  memRd,
  output logic [ADDR_WIDTH-1:0] inAddr,
  output logic                  init,
  output logic                  enMac,
  output logic                  enReLU,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    READ,
    DRAIN,
    RELU,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NUM_INPUTS - 1);

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  mac_q;
  logic                  at_last;

  assign at_last = (cnt == LAST);
  assign inAddr  = cnt;
  assign enMac   = mac_q;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // element counter: cleared on entry, walks in READ, holds at last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      case (state)
        INIT:    cnt <= '0;
        READ:    if (!at_last) cnt <= cnt + 1'b1;
        DONE:    cnt <= '0;
        default: cnt <= cnt;
      endcase
    end
  end

  // MAC enable trails the read strobe by the memory read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mac_q <= 1'b0;
    else      mac_q <= (state == READ);
  end

  // next state and Moore output decode
  always_comb begin
    state_nx = state;
    memRd    = 1'b0;
    init     = 1'b0;
    enReLU   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = INIT;
      end
      INIT: begin
        init     = 1'b1;
        state_nx = READ;
      end
      READ: begin
        memRd = 1'b1;
        if (at_last) state_nx = DRAIN;
      end
      DRAIN: begin
        state_nx = RELU;
      end
      RELU: begin
        enReLU   = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_neuron_controller.sv
// tb_neuron_controller: scoreboard bench for neuron_controller.
// Three instances (N=4, N=62 with neuron models, N=1).
module tb_neuron_controller;

  logic clk = 1'b0;
  logic rst;
  logic start4, start62, start1;

  logic       rd4, i4, m4, r4, b4, d4;
  logic [2:0] a4;
  logic       rd62, i62, m62, r62, b62, d62;
  logic [5:0] a62;
  logic       rd1, i1, m1, r1, b1, d1;
  logic [0:0] a1;

  always #5 clk = ~clk;

  neuron_controller #(.NUM_INPUTS(4), .ADDR_WIDTH(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .memRd(rd4), .inAddr(a4), .init(i4), .enMac(m4),
    .enReLU(r4), .busy(b4), .done(d4)
  );

  neuron_controller #(.NUM_INPUTS(62), .ADDR_WIDTH(6)) dut62 (
    .clk(clk), .rst(rst), .start(start62),
    .memRd(rd62), .inAddr(a62), .init(i62), .enMac(m62),
    .enReLU(r62), .busy(b62), .done(d62)
  );

  neuron_controller #(.NUM_INPUTS(1), .ADDR_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .memRd(rd1), .inAddr(a1), .init(i1), .enMac(m1),
    .enReLU(r1), .busy(b1), .done(d1)
  );

  // datapath model for N=62: shared data memory, 4 neurons
  int dmem [62];
  int wmem [4][62];
  int d_rd;
  int w_rd [4];
  int acc  [4];
  int nout [4];
  int mac_cnt;

  function automatic int sat(input int x);
    if (x < 0)    return 0;
    if (x > 2000) return 2000;
    return x;
  endfunction

  always @(posedge clk) begin
    if (rd62) begin
      d_rd <= dmem[a62];
      for (int j = 0; j < 4; j++) w_rd[j] <= wmem[j][a62];
    end
  end

  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (i62)      acc[j] <= 0;
      else if (m62) acc[j] <= acc[j] + d_rd * w_rd[j];
      if (r62)      nout[j] <= sat(acc[j]);
    end
    if (i62)      mac_cnt <= 0;
    else if (m62) mac_cnt <= mac_cnt + 1;
  end

  // {memRd, addr[5:0], init, enMac, enReLU, busy, done}
  function automatic logic [11:0] obs(input int w);
    logic [11:0] v = '0;
    case (w)
      1:  v = {rd1, 6'(a1), i1, m1, r1, b1, d1};
      4:  v = {rd4, 6'(a4), i4, m4, r4, b4, d4};
      62: v = {rd62, a62, i62, m62, r62, b62, d62};
      default: v = '0;
    endcase
    return v;
  endfunction

  // expected outputs in cycle c after start sampled at end of cycle 0
  function automatic logic [11:0] exp_vec(input int n, input int c);
    logic [11:0] v = '0;
    v[11] = (c >= 2) && (c <= n + 1);
    if (v[11]) v[10:5] = 6'(c - 2);
    v[4] = (c == 1);
    v[3] = (c >= 3) && (c <= n + 2);
    v[2] = (c == n + 3);
    v[1] = (c >= 1) && (c <= n + 4);
    v[0] = (c == n + 4);
    return v;
  endfunction

  logic [11:0] exp_q [$];
  int          gold_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] a;
    #2;
    rst = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      int id;
      id = (w == 0) ? 1 : (w == 1) ? 4 : 62;
      a = obs(id);
      n_cmp++;
      if (a !== 12'h000) begin
        n_err++;
        $display("FAIL reset_async dut%0d: got %h want 000", id, a);
      end
    end
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) exp_q.push_back(12'h000);
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      a = obs(4);
      n_cmp++;
      if (a !== exp_q.pop_front()) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: got %h want 000", c, a);
      end
    end
  endtask

  task automatic test_nominal();
    logic [11:0] e, a;
    tick();
    start4 = 1'b1;
    for (int c = 1; c <= 9; c++) exp_q.push_back(exp_vec(4, c));
    for (int c = 1; c <= 9; c++) begin
      tick();
      start4 = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      a = obs(4);
      if (!e[11]) a[10:5] = '0;
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL nominal cycle %0d: got %h want %h", c, a, e);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [11:0] e, a;
    tick();
    start4 = 1'b1;
    for (int c = 1; c <= 14; c++) exp_q.push_back(exp_vec(4, c));
    for (int c = 1; c <= 14; c++) begin
      tick();
      start4 = (c == 3) || (c == 5);
      @(negedge clk);
      e = exp_q.pop_front();
      a = obs(4);
      if (!e[11]) a[10:5] = '0;
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL ignore_start cycle %0d: got %h want %h", c, a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e, a;
    int macs;
    macs = 0;
    tick();
    start1 = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int c = 1; c <= 6; c++) exp_q.push_back(exp_vec(1, c));
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h000);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 18) start1 = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      a = obs(1);
      if (!e[11]) a[10:5] = '0;
      if (m1) macs++;
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL back_to_back cycle %0d: got %h want %h", i, a, e);
      end
    end
    n_cmp++;
    if (macs !== 3) begin
      n_err++;
      $display("FAIL b2b_mac_count: got %0d want 3", macs);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e, a;
    tick();
    start4 = 1'b1;
    for (int c = 1; c <= 3; c++) exp_q.push_back(exp_vec(4, c));
    for (int c = 1; c <= 3; c++) begin
      tick();
      start4 = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      a = obs(4);
      if (!e[11]) a[10:5] = '0;
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL mid_pre cycle %0d: got %h want %h", c, a, e);
      end
    end
    tick();
    rst = 1'b0;
    #1;
    a = obs(4);
    n_cmp++;
    if (a !== 12'h000) begin
      n_err++;
      $display("FAIL mid_async: got %h want 000", a);
    end
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      a = obs(4);
      n_cmp++;
      if (a !== 12'h000) begin
        n_err++;
        $display("FAIL mid_no_done cycle %0d: got %h want 000", c, a);
      end
    end
    tick();
    start4 = 1'b1;
    for (int c = 1; c <= 9; c++) exp_q.push_back(exp_vec(4, c));
    for (int c = 1; c <= 9; c++) begin
      tick();
      start4 = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      a = obs(4);
      if (!e[11]) a[10:5] = '0;
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL mid_restart cycle %0d: got %h want %h", c, a, e);
      end
    end
  endtask

  task automatic test_end_to_end();
    int lat, g, sum;
    for (int k = 0; k < 62; k++) begin
      dmem[k] = ((k * 37) % 41) - 20;
      for (int j = 0; j < 4; j++)
        wmem[j][k] = (((j + 3) * k * 11) % 29) - 14 + 4 * j;
    end
    for (int j = 0; j < 4; j++) begin
      sum = 0;
      for (int k = 0; k < 62; k++) sum += dmem[k] * wmem[j][k];
      gold_q.push_back(sat(sum));
    end
    lat = -1;
    tick();
    start62 = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      start62 = 1'b0;
      @(negedge clk);
      if (d62) begin
        lat = i;
        break;
      end
    end
    n_cmp++;
    if (lat !== 66) begin
      n_err++;
      $display("FAIL e2e_latency: got %0d want 66", lat);
    end
    n_cmp++;
    if (mac_cnt !== 62) begin
      n_err++;
      $display("FAIL e2e_mac_count: got %0d want 62", mac_cnt);
    end
    for (int j = 0; j < 4; j++) begin
      g = gold_q.pop_front();
      n_cmp++;
      if (nout[j] !== g) begin
        n_err++;
        $display("FAIL e2e_neuron%0d: got %0d want %0d", j, nout[j], g);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    start4  = 1'b0;
    start62 = 1'b0;
    start1  = 1'b0;
    test_reset();
    test_nominal();
    tick();
    test_ignore_start();
    test_back_to_back();
    tick();
    test_reset_mid();
    tick();
    test_end_to_end();
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
